// File: rtl/bayer_gray.sv
// Bayer 2x2 quad averager: collapses each R/G1/G2/B quad of the raw stream
// into one grayscale pixel at half resolution, with output coordinates.
module bayer_gray #(
  parameter int RAW_W  = 2560,
  parameter int RAW_H  = 1920,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] raw_data,
  input  logic              raw_valid,
  input  logic [11:0]       raw_x,
  input  logic [11:0]       raw_y,
  output logic [DATA_W-1:0] gray_data,
  output logic              gray_valid,
  output logic [10:0]       gray_x,
  output logic [10:0]       gray_y,
  output logic              frame_done
);

  localparam int AW = $clog2(RAW_W / 2);
  localparam int SW = DATA_W + 1;
  localparam logic [12:0] W_LIM   = 13'(RAW_W);
  localparam logic [12:0] H_LIM   = 13'(RAW_H);
  localparam logic [11:0] X_LAST  = 12'(RAW_W - 1);
  localparam logic [10:0] GX_LAST = 11'(RAW_W / 2 - 1);
  localparam logic [10:0] GY_LAST = 11'(RAW_H / 2 - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t            state;
  logic [11:0]       fill_row;
  logic [DATA_W-1:0] pair_lat;
  logic [11:0]       pair_row;
  logic              pair_ok;
  logic [SW-1:0]     ram [RAW_W/2];
  logic [SW-1:0]     ram_q;

  logic              accept, col_odd, row_odd, pair_hit, restart, emit_row;
  logic              ram_we, ram_re, do_emit;
  logic [AW-1:0]     addr;
  logic [SW-1:0]     pair_sum;
  logic [SW:0]       quad_sum;

  assign accept   = raw_valid && ({1'b0, raw_x} < W_LIM) && ({1'b0, raw_y} < H_LIM);
  assign col_odd  = raw_x[0];
  assign row_odd  = raw_y[0];
  assign pair_hit = accept && col_odd && pair_ok && (raw_y == pair_row);
  assign restart  = accept && (raw_x == '0) && (raw_y == '0);
  assign emit_row = (raw_y == fill_row + 12'd1);
  assign addr     = raw_x[AW:1];
  assign pair_sum = {1'b0, pair_lat} + {1'b0, raw_data};
  assign quad_sum = {1'b0, ram_q} + {1'b0, pair_sum};

  always_comb begin
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    do_emit = 1'b0;
    if (!restart) begin
      case (state)
        FILL: ram_we = !row_odd && pair_hit;
        EMIT: if (accept && emit_row) begin
          ram_re  = !col_odd;
          do_emit = pair_hit;
        end
        default: ;
      endcase
    end
  end

  // Line buffer: no reset, every address read in an odd row is rewritten by the even row before it.
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr] <= pair_sum;
    if (ram_re) ram_q <= ram[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill_row   <= '0;
      pair_lat   <= '0;
      pair_row   <= '0;
      pair_ok    <= 1'b0;
      gray_valid <= 1'b0;
      gray_data  <= '0;
      gray_x     <= '0;
      gray_y     <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept && !col_odd) begin
        pair_lat <= raw_data;
        pair_row <= raw_y;
        pair_ok  <= 1'b1;
      end else if (accept) begin
        pair_ok  <= 1'b0;
      end

      if (restart) begin
        state    <= FILL;
        fill_row <= '0;
      end else if (accept) begin
        case (state)
          IDLE: if (raw_x == '0 && !row_odd) begin
            state    <= FILL;
            fill_row <= raw_y;
          end
          FILL: if (row_odd) begin
            state <= IDLE;
          end else begin
            fill_row <= raw_y;
            if (pair_hit && raw_x == X_LAST) state <= EMIT;
          end
          EMIT: if (emit_row) begin
            if (raw_x == X_LAST) state <= FILL;
          end else if (!row_odd) begin
            // Another even row: it becomes the row being filled.
            state    <= FILL;
            fill_row <= raw_y;
          end else begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      gray_valid <= do_emit;
      frame_done <= do_emit && (raw_x[11:1] == GX_LAST) && (raw_y[11:1] == GY_LAST);
      if (do_emit) begin
        gray_data <= quad_sum[SW:2];
        gray_x    <= raw_x[11:1];
        gray_y    <= raw_y[11:1];
      end
    end
  end

endmodule

// File: tb/tb_bayer_gray.sv
// Scoreboard bench for bayer_gray on an 8x4 raw frame.
module tb_bayer_gray;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] raw_data;
  logic        raw_valid;
  logic [11:0] raw_x, raw_y;
  logic [11:0] gray_data;
  logic        gray_valid;
  logic [10:0] gray_x, gray_y;
  logic        frame_done;

  bayer_gray #(.RAW_W(8), .RAW_H(4), .DATA_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .raw_data(raw_data), .raw_valid(raw_valid), .raw_x(raw_x), .raw_y(raw_y),
    .gray_data(gray_data), .gray_valid(gray_valid),
    .gray_x(gray_x), .gray_y(gray_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {int d; int x; int y; int fd;} exp_t;
  exp_t q[$];
  int pix[4][8];
  int n_vec = 0;
  int n_err = 0;
  int last_d = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gray_valid && prev_valid) check("consecutive_strobe", 1, 0);
      if (frame_done && !gray_valid) check("fd_without_valid", int'(gray_valid), 1);
      if (gray_valid) begin
        check("strobe_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("gray_data", gray_data, e.d);
          check("gray_x", gray_x, e.x);
          check("gray_y", gray_y, e.y);
          check("frame_done", frame_done, e.fd);
          last_d = e.d;
        end
      end
    end
    prev_valid = gray_valid;
  end

  task automatic beat(input int x, input int y, input int d);
    raw_valid = 1'b1;
    raw_x     = 12'(x);
    raw_y     = 12'(y);
    raw_data  = 12'(d);
    @(posedge clk); #1;
    raw_valid = 1'b0;
    raw_data  = 12'($urandom);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic send_row(input int y, input int xs, input int xe, input bit ex);
    for (int x = xs; x < xe; x++) begin
      if (ex && (y % 2 == 1) && (x % 2 == 1)) begin
        exp_t e;
        e.d  = (pix[y-1][x-1] + pix[y-1][x] + pix[y][x-1] + pix[y][x]) / 4;
        e.x  = x / 2;
        e.y  = y / 2;
        e.fd = ((x / 2 == 3) && (y / 2 == 1)) ? 1 : 0;
        q.push_back(e);
      end
      beat(x, y, pix[y][x]);
    end
  endtask

  task automatic rand_pix();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) pix[y][x] = int'($urandom_range(0, 4095));
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, gray_valid, 0);
    check({tag, "_data"}, gray_data, 0);
    check({tag, "_x"}, gray_x, 0);
    check({tag, "_y"}, gray_y, 0);
    check({tag, "_fd"}, frame_done, 0);
  endtask

  task automatic full_frame();
    for (int y = 0; y < 4; y++) send_row(y, 0, 8, 1'b1);
  endtask

  initial begin
    int row0[8] = '{100, 200, 4095, 4095, 1, 1, 7, 9};
    int row1[8] = '{300, 400, 4095, 4095, 1, 2, 5, 3};
    rst_n = 1'b0; raw_valid = 1'b0; raw_x = '0; raw_y = '0; raw_data = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic quad (250), all-4095 quad, 1/1/1/2 truncation, then random frame
    rand_pix();
    for (int x = 0; x < 8; x++) begin pix[0][x] = row0[x]; pix[1][x] = row1[x]; end
    full_frame();
    settle("frame1_missing");
    check("hold_data", gray_data, last_d);
    rand_pix();
    full_frame();
    settle("frame2_missing");

    // odd row with no filled even row, then a good even/odd pair
    rand_pix();
    send_row(1, 0, 8, 1'b0);
    send_row(2, 0, 8, 1'b0);
    send_row(3, 0, 8, 1'b1);
    settle("oddstart_missing");

    // short even row followed by an odd row: no strobes
    rand_pix();
    send_row(0, 0, 4, 1'b0);
    send_row(1, 0, 8, 1'b0);
    settle("shortrow_missing");

    // out-of-range beats inside an odd row must not disturb it
    rand_pix();
    send_row(0, 0, 8, 1'b0);
    send_row(1, 0, 1, 1'b1);
    beat(8, 1, 4095);
    beat(1, 4, 4095);
    beat(0, 4, 4095);
    send_row(1, 1, 8, 1'b1);
    settle("oor_missing");

    // reset in the middle of an odd row after two strobes
    rand_pix();
    send_row(0, 0, 8, 1'b0);
    send_row(1, 0, 5, 1'b1);
    settle("prereset_missing");
    rst_n = 1'b0;
    #2 check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_pix();
    full_frame();
    settle("postreset_missing");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bayer_gray.md
# bayer_gray

Upstream feeder for the edge-detection `convolution` stage. Accepts the camera's raw Bayer stream, averages each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grayscale pixel, and emits it with 11-bit output coordinates on a single-cycle strobe. That strobe drives the convolution stage's `read`/`data_in`/`x`/`y` inputs directly. It halves resolution in both axes: 2560x1920 raw in, 1280x960 gray out.

## Interface

**Parameters**
- `RAW_W`, default 2560: raw pixels per line; even; `RAW_W/2` must be ≤ 2048.
- `RAW_H`, default 1920: raw lines per frame; even; `RAW_H/2` must be ≤ 2048.
- `DATA_W`, default 12: raw and gray sample width.

**Ports** (clock and reset first)
- `clk`, input, 1: single clock for all logic.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `raw_data`, input, `DATA_W`: raw Bayer sample.
- `raw_valid`, input, 1: `raw_data`, `raw_x` and `raw_y` are valid this cycle. Gaps are allowed.
- `raw_x`, input, 12: raw column.
- `raw_y`, input, 12: raw row.
- `gray_data`, output, `DATA_W`: averaged gray pixel.
- `gray_valid`, output, 1: one-cycle strobe; feeds the convolution stage's `read`.
- `gray_x`, output, 11: equals `raw_x>>1`.
- `gray_y`, output, 11: equals `raw_y>>1`.
- `frame_done`, output, 1: one-cycle pulse together with the gray pixel at (`RAW_W/2`-1, `RAW_H/2`-1).

## Operation

**Beat acceptance**
- A beat is accepted when `raw_valid` is high and `raw_x` < `RAW_W` and `raw_y` < `RAW_H`. Any other beat is ignored entirely.

**Pair register**
- Accepted even-column beat: latch `raw_data`, set `pair_ok`.
- Accepted odd-column beat with `pair_ok` set: form a 13-bit `pair_sum` (latched + current), then clear `pair_ok`.
- Odd-column beat with `pair_ok` clear: dropped.
- `pair_ok` is also cleared whenever `raw_y` differs from the row of the latched sample.

**Line buffer**
- One RAM of `RAW_W/2` × 13 bits, addressed by `raw_x>>1`.
- Synchronous read. Output holds between reads.

**FSM: IDLE, FILL, EMIT**
- IDLE: waits for an accepted beat with `raw_x`==0 and even `raw_y`; then goes to FILL and processes that beat.
- FILL (even row):
  - Each `pair_sum` is written to RAM[`raw_x>>1`].
  - After the pair at `raw_x`==`RAW_W`-1 is written, go to EMIT.
  - An accepted beat with odd `raw_y` goes to IDLE and is dropped (short even row).
- EMIT (odd row, `raw_y` = filled row + 1):
  - Even-column beat: issue RAM read at `raw_x>>1`.
  - Odd-column beat with `pair_ok` set: `sum = RAM + pair_sum` (14-bit); `gray_data = sum[13:2]` (truncating divide by 4, no rounding); `gray_valid` pulses.
  - After the pair at `raw_x`==`RAW_W`-1, go to FILL.
  - An accepted beat on an even row that is not filled-row + 1: go to FILL and treat it as the first beat of that row.
  - An accepted beat on any other odd row: go to IDLE.
- `raw_y`==0 with `raw_x`==0 in any state restarts the frame (enter FILL).

**Arithmetic**
- All sums are unsigned with full-width carry; no saturation is needed (4 × 4095 = 16380 fits in 14 bits).

**Reset**
- Asserting `rst_n` low, including mid-line, immediately forces all of the following:
  - FSM to IDLE, `pair_ok`=0.
  - `gray_valid`=0, `gray_data`=0, `gray_x`=0, `gray_y`=0, `frame_done`=0.
- RAM contents are don't-care; the first even row after reset rewrites every address that gets read.

## Timing

- Output latency: `gray_*` and `frame_done` are registered and appear the cycle after the odd-row, odd-column beat is accepted.
- `gray_valid` is high for exactly one cycle per output pixel and never on two consecutive raw-valid-gapless cycles.
- RAM read latency: 1 cycle. The read is issued on the even-column beat of the odd row; data is stable by the matching odd-column beat, regardless of any `raw_valid` gaps between them.
- Even-row write and odd-row read never target the same address in the same cycle.
- No backpressure: the downstream stage must accept every `gray_valid` strobe.
- `gray_data`, `gray_x`, `gray_y` hold their last values while `gray_valid` is low.

## Test plan

Benches use `RAW_W`=8 and `RAW_H`=4 unless noted.

- **Basic quad:** row 0 x0..1 = 100, 200; row 1 x0..1 = 300, 400 -> one strobe, `gray_data`=250, `gray_x`=0, `gray_y`=0, one cycle after the row-1 x1 beat.
- **Saturation and truncation:** a quad of all 4095 -> 4095. A quad of 1, 1, 1, 2 -> 1.
- **Full frame with random `raw_valid` gaps (0–3 idle cycles):**
  - Exactly 8 strobes in raster order with correct coordinates.
  - Values match a reference model.
  - `frame_done` coincides with (3, 1).
- **Odd row without a filled even row** (start streaming at `raw_y`=1) -> no strobes until the next even row completes. Also check that a short even row (4 of 8 pixels, then an odd-row beat) -> IDLE, no strobes on that odd row.
- **Reset mid-odd-row** after 2 strobes -> all outputs 0 during reset. The next full frame produces correct values.
- **Out-of-range beat** (`raw_x`=8 or `raw_y`=4 with `raw_valid`) -> ignored; no state change and no strobe.
